// File: rtl/fetch_instruction_buffer.sv
// Decoupling FIFO between fetch and decode with in-flight slot reservation.
// Optional macro FETCH_BUFFER_PREDECODE_EN adds a stored branch/jump predecode flag.
module fetch_instruction_buffer #(
    parameter int DEPTH        = 4,
    parameter int ID_WIDTH     = 3,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       fetch_issued,
    input  logic                       fetch_retire,
    input  logic                       fetch_complete,
    input  logic [ID_WIDTH-1:0]        fetch_id,
    input  logic [31:0]                fetch_pc,
    input  logic [31:0]                fetch_instruction,
    input  logic                       fetch_ok,
    input  logic [4:0]                 fetch_error_code,
    output logic                       fetch_hold_req,
    output logic                       decode_valid,
    input  logic                       decode_ready,
    output logic [ID_WIDTH-1:0]        decode_id,
    output logic [31:0]                decode_pc,
    output logic [31:0]                decode_instruction,
    output logic                       decode_ok,
    output logic [4:0]                 decode_error_code,
`ifdef FETCH_BUFFER_PREDECODE_EN
    output logic                       decode_is_branch_or_jump,
`endif
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int INF_W = $clog2(MAX_INFLIGHT) + 1;
    localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [INF_W-1:0] inflight;
    logic [SUM_W-1:0] load;
    logic             primed;
    logic             push;
    logic             pop;

    logic [ID_WIDTH-1:0] mem_id    [DEPTH];
    logic [31:0]         mem_pc    [DEPTH];
    logic [31:0]         mem_instr [DEPTH];
    logic                mem_ok    [DEPTH];
    logic [4:0]          mem_err   [DEPTH];

    assign push = fetch_complete & ~flush;
    assign pop  = decode_valid & decode_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    // Flushed requests still retire through fetch, so flush leaves this alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inflight <= '0;
        else      inflight <= inflight + INF_W'(fetch_issued) - INF_W'(fetch_retire);
    end

    // Storage is not reset; primed masks the payload until the first write lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      primed <= 1'b0;
        else if (push) primed <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]    <= fetch_id;
            mem_pc[wr_ptr]    <= fetch_pc;
            mem_instr[wr_ptr] <= fetch_instruction;
            mem_ok[wr_ptr]    <= fetch_ok;
            mem_err[wr_ptr]   <= fetch_error_code;
        end
    end

`ifdef FETCH_BUFFER_PREDECODE_EN
    logic       mem_br [DEPTH];
    logic [4:0] push_opcode;
    logic       push_is_branch;

    // JAL, JALR and BRANCH major opcodes; a faulted fetch never predecodes as control flow.
    assign push_opcode    = fetch_instruction[6:2];
    assign push_is_branch = fetch_ok & ((push_opcode == 5'b11011) |
                                        (push_opcode == 5'b11001) |
                                        (push_opcode == 5'b11000));

    always_ff @(posedge clk) begin
        if (push) mem_br[wr_ptr] <= push_is_branch;
    end

    assign decode_is_branch_or_jump = primed ? mem_br[rd_ptr] : 1'b0;
`endif

    assign load           = SUM_W'(count) + SUM_W'(inflight);
    assign fetch_hold_req = (load >= SUM_W'(DEPTH));
    assign decode_valid   = (count != '0);
    assign occupancy      = count;

    assign decode_id          = primed ? mem_id[rd_ptr]    : '0;
    assign decode_pc          = primed ? mem_pc[rd_ptr]    : '0;
    assign decode_instruction = primed ? mem_instr[rd_ptr] : '0;
    assign decode_ok          = primed ? mem_ok[rd_ptr]    : 1'b0;
    assign decode_error_code  = primed ? mem_err[rd_ptr]   : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(fetch_complete && (count == CNT_W'(DEPTH)) && !pop))
        else $error("fetch_complete into a full buffer");

    a_no_retire_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(fetch_retire && (inflight == '0)))
        else $error("fetch_retire with no request in flight");

    a_no_issue_on_hold: assert property (@(posedge clk) disable iff (!rst)
        !(fetch_issued && fetch_hold_req))
        else $error("fetch_issued while fetch_hold_req asserted");

    a_inflight_bound: assert property (@(posedge clk) disable iff (!rst)
        (32'(inflight) <= MAX_INFLIGHT))
        else $error("in-flight count exceeds MAX_INFLIGHT");

endmodule

// File: tb/tb_fetch_instruction_buffer.sv
// Directed self-checking bench for fetch_instruction_buffer (DEPTH=4, MAX_INFLIGHT=2).
module tb_fetch_instruction_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        fetch_issued;
    logic        fetch_retire;
    logic        fetch_complete;
    logic [2:0]  fetch_id;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instruction;
    logic        fetch_ok;
    logic [4:0]  fetch_error_code;
    logic        fetch_hold_req;
    logic        decode_valid;
    logic        decode_ready;
    logic [2:0]  decode_id;
    logic [31:0] decode_pc;
    logic [31:0] decode_instruction;
    logic        decode_ok;
    logic [4:0]  decode_error_code;
`ifdef FETCH_BUFFER_PREDECODE_EN
    logic        decode_is_branch_or_jump;
`endif
    logic [2:0]  occupancy;

    int tests = 0;
    int fails = 0;

    fetch_instruction_buffer #(.DEPTH(4), .ID_WIDTH(3), .MAX_INFLIGHT(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fetch_issued(fetch_issued), .fetch_retire(fetch_retire),
        .fetch_complete(fetch_complete), .fetch_id(fetch_id), .fetch_pc(fetch_pc),
        .fetch_instruction(fetch_instruction), .fetch_ok(fetch_ok),
        .fetch_error_code(fetch_error_code), .fetch_hold_req(fetch_hold_req),
        .decode_valid(decode_valid), .decode_ready(decode_ready),
        .decode_id(decode_id), .decode_pc(decode_pc),
        .decode_instruction(decode_instruction), .decode_ok(decode_ok),
        .decode_error_code(decode_error_code),
`ifdef FETCH_BUFFER_PREDECODE_EN
        .decode_is_branch_or_jump(decode_is_branch_or_jump),
`endif
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; fetch_issued = 0; fetch_retire = 0; fetch_complete = 0;
        fetch_id = 0; fetch_pc = 0; fetch_instruction = 0; fetch_ok = 1; fetch_error_code = 0;
    endtask

    task automatic push_only(input logic [2:0] id, input logic [31:0] pc);
        fetch_complete = 1; fetch_id = id; fetch_pc = pc; fetch_instruction = 32'h13 + pc; fetch_ok = 1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 0; decode_ready = 0; idle();
        repeat (2) tick();
        tests++; if (decode_valid !== 1'b0)   begin fails++; $display("FAIL reset_valid got %0b want 0", decode_valid); end
        tests++; if (fetch_hold_req !== 1'b0) begin fails++; $display("FAIL reset_hold got %0b want 0", fetch_hold_req); end
        tests++; if (occupancy !== 3'd0)      begin fails++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        tests++; if ({decode_id, decode_pc, decode_instruction, decode_ok, decode_error_code} !== '0)
            begin fails++; $display("FAIL reset_payload got pc=%h instr=%h want zeros", decode_pc, decode_instruction); end
        rst = 1;
        tick();
    endtask

    task automatic test_single_fetch();
        decode_ready = 1;
        fetch_complete = 1; fetch_id = 3'd2; fetch_pc = 32'h8000_0000;
        fetch_instruction = 32'h0000_0013; fetch_ok = 1;
        #1;
        tests++; if (decode_valid !== 1'b0) begin fails++; $display("FAIL single_no_bypass got %0b want 0", decode_valid); end
        tick();
        idle();
        tests++; if (decode_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %0b want 1", decode_valid); end
        tests++; if (decode_id !== 3'd2)    begin fails++; $display("FAIL single_id got %0d want 2", decode_id); end
        tests++; if (decode_pc !== 32'h8000_0000) begin fails++; $display("FAIL single_pc got %h want 80000000", decode_pc); end
        tests++; if (decode_instruction !== 32'h13 || decode_ok !== 1'b1)
            begin fails++; $display("FAIL single_instr got %h ok=%0b want 00000013 ok=1", decode_instruction, decode_ok); end
        tick();
        tests++; if (occupancy !== 3'd0 || decode_valid !== 1'b0)
            begin fails++; $display("FAIL single_drain got occ=%0d valid=%0b want 0 0", occupancy, decode_valid); end
        decode_ready = 0;
    endtask

    task automatic test_fill_backpressure();
        decode_ready = 0;
        for (int i = 0; i < 4; i++) begin
            fetch_issued = 1;
            tick();
            fetch_issued = 0;
            tests++; if (fetch_hold_req !== (i == 3))
                begin fails++; $display("FAIL fill_hold_issue%0d got %0b want %0b", i, fetch_hold_req, (i == 3)); end
            fetch_complete = 1; fetch_retire = 1; fetch_id = 3'(i); fetch_pc = 32'h100 + 32'(4 * i);
            tick();
            idle();
            tests++; if (occupancy !== 3'(i + 1))
                begin fails++; $display("FAIL fill_occ%0d got %0d want %0d", i, occupancy, i + 1); end
        end
        tests++; if (fetch_hold_req !== 1'b1) begin fails++; $display("FAIL fill_hold_full got %0b want 1", fetch_hold_req); end
        decode_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (decode_valid !== 1'b1 || decode_pc !== 32'h100 + 32'(4 * i))
                begin fails++; $display("FAIL fill_drain%0d got valid=%0b pc=%h want 1 %h", i, decode_valid, decode_pc, 32'h100 + 32'(4 * i)); end
            tick();
        end
        decode_ready = 0;
        tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL fill_empty got %0d want 0", occupancy); end
    endtask

    task automatic test_wrap_push_pop();
        push_only(3'd0, 32'h300);
        push_only(3'd1, 32'h304);
        push_only(3'd2, 32'h308);
        fetch_issued = 1;
        tick();
        fetch_issued = 0;
        tests++; if (occupancy !== 3'd3 || fetch_hold_req !== 1'b1)
            begin fails++; $display("FAIL wrap_setup got occ=%0d hold=%0b want 3 1", occupancy, fetch_hold_req); end
        decode_ready = 1; fetch_complete = 1; fetch_retire = 1; fetch_id = 3'd3; fetch_pc = 32'h30C;
        #1;
        tests++; if (decode_pc !== 32'h300) begin fails++; $display("FAIL wrap_head got %h want 300", decode_pc); end
        tick();
        idle();
        tests++; if (occupancy !== 3'd3 || fetch_hold_req !== 1'b0)
            begin fails++; $display("FAIL wrap_pushpop got occ=%0d hold=%0b want 3 0", occupancy, fetch_hold_req); end
        for (int i = 1; i < 4; i++) begin
            tests++; if (decode_pc !== 32'h300 + 32'(4 * i) || decode_id !== 3'(i))
                begin fails++; $display("FAIL wrap_order%0d got pc=%h id=%0d want %h %0d", i, decode_pc, decode_id, 32'h300 + 32'(4 * i), i); end
            tick();
        end
        decode_ready = 0;
        tests++; if (decode_valid !== 1'b0) begin fails++; $display("FAIL wrap_empty got %0b want 0", decode_valid); end
    endtask

    task automatic test_flush();
        fetch_issued = 1; tick();
        fetch_issued = 1; tick();
        idle();
        push_only(3'd0, 32'h400);
        push_only(3'd1, 32'h404);
        push_only(3'd2, 32'h408);
        tests++; if (occupancy !== 3'd3 || fetch_hold_req !== 1'b1)
            begin fails++; $display("FAIL flush_setup got occ=%0d hold=%0b want 3 1", occupancy, fetch_hold_req); end
        flush = 1; decode_ready = 1; fetch_complete = 1; fetch_pc = 32'h40C;
        tick();
        idle(); decode_ready = 0;
        tests++; if (occupancy !== 3'd0 || decode_valid !== 1'b0 || fetch_hold_req !== 1'b0)
            begin fails++; $display("FAIL flush_clear got occ=%0d valid=%0b hold=%0b want 0 0 0", occupancy, decode_valid, fetch_hold_req); end
        push_only(3'd4, 32'h500);
        tests++; if (fetch_hold_req !== 1'b0 || decode_pc !== 32'h500)
            begin fails++; $display("FAIL flush_repush got hold=%0b pc=%h want 0 500", fetch_hold_req, decode_pc); end
        push_only(3'd5, 32'h504);
        tests++; if (fetch_hold_req !== 1'b1)
            begin fails++; $display("FAIL flush_inflight_kept got hold=%0b want 1", fetch_hold_req); end
        fetch_retire = 1; tick();
        fetch_retire = 1; tick();
        idle();
        fetch_issued = 1; tick();
        idle();
        tests++; if (fetch_hold_req !== 1'b0)
            begin fails++; $display("FAIL flush_retired got hold=%0b want 0", fetch_hold_req); end
        fetch_issued = 1; tick();
        idle();
        tests++; if (fetch_hold_req !== 1'b1)
            begin fails++; $display("FAIL flush_reissue got hold=%0b want 1", fetch_hold_req); end
        fetch_retire = 1; tick();
        fetch_retire = 1; tick();
        idle();
        decode_ready = 1; tick(); tick(); decode_ready = 0;
        tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL flush_drain got %0d want 0", occupancy); end
    endtask

    task automatic test_fault_entry();
        fetch_complete = 1; fetch_id = 3'd6; fetch_pc = 32'h2000;
        fetch_instruction = 32'h0000_006F; fetch_ok = 0; fetch_error_code = 5'd12;
        tick();
        idle();
        tests++; if (decode_valid !== 1'b1 || decode_ok !== 1'b0 || decode_error_code !== 5'd12 || decode_pc !== 32'h2000)
            begin fails++; $display("FAIL fault_fields got v=%0b ok=%0b ec=%0d pc=%h want 1 0 12 2000",
                                    decode_valid, decode_ok, decode_error_code, decode_pc); end
`ifdef FETCH_BUFFER_PREDECODE_EN
        tests++; if (decode_is_branch_or_jump !== 1'b0)
            begin fails++; $display("FAIL fault_predecode got %0b want 0", decode_is_branch_or_jump); end
`endif
        decode_ready = 1;
        fetch_complete = 1; fetch_id = 3'd7; fetch_pc = 32'h2004; fetch_instruction = 32'h0000_006F; fetch_ok = 1;
        tick();
        idle();
        tests++; if (decode_ok !== 1'b1 || decode_pc !== 32'h2004 || occupancy !== 3'd1)
            begin fails++; $display("FAIL jal_fields got ok=%0b pc=%h occ=%0d want 1 2004 1", decode_ok, decode_pc, occupancy); end
`ifdef FETCH_BUFFER_PREDECODE_EN
        tests++; if (decode_is_branch_or_jump !== 1'b1)
            begin fails++; $display("FAIL jal_predecode got %0b want 1", decode_is_branch_or_jump); end
`endif
        tick();
        decode_ready = 0;
    endtask

    task automatic test_async_reset();
        push_only(3'd1, 32'h600);
        push_only(3'd2, 32'h604);
        fetch_issued = 1; tick();
        idle();
        tests++; if (occupancy !== 3'd2 || decode_valid !== 1'b1)
            begin fails++; $display("FAIL areset_setup got occ=%0d valid=%0b want 2 1", occupancy, decode_valid); end
        #2;
        rst = 0;
        #1;
        tests++; if (decode_valid !== 1'b0 || occupancy !== 3'd0 || fetch_hold_req !== 1'b0 || decode_pc !== 32'h0)
            begin fails++; $display("FAIL areset_immediate got valid=%0b occ=%0d hold=%0b pc=%h want 0 0 0 0",
                                    decode_valid, occupancy, fetch_hold_req, decode_pc); end
        tick();
        rst = 1;
        fetch_issued = 1; tick();
        fetch_issued = 1; tick();
        idle();
        tests++; if (fetch_hold_req !== 1'b0)
            begin fails++; $display("FAIL areset_inflight got hold=%0b want 0", fetch_hold_req); end
        fetch_retire = 1; tick();
        fetch_retire = 1; tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_fill_backpressure();
        test_wrap_push_pop();
        test_flush();
        test_fault_entry();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
